// File: rtl/filtro_iir2_sec.sv
// Direct-form-II biquad section, one shared multiplier, one accumulator.
// Define FILTRO_SATURACION_EN to clamp instead of wrap on overflow.
module filtro_iir2_sec #(
    parameter int N    = 16,
    parameter int FRAC = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [N-1:0] UK,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] A2,
    input  logic [N-1:0] B0,
    input  logic [N-1:0] B1,
    input  logic [N-1:0] B2,
    output logic [N-1:0] YK,
    output logic         out_valid,
    output logic         sat_flag
);

    localparam int AW = 2 * N + 2;
    localparam int PW = 2 * N;

    typedef enum logic [2:0] {
        IDLE, MAC_A1, MAC_A2, NORM_F,
        MAC_B0, MAC_B1, MAC_B2, NORM_Y
    } state_t;

    state_t state, state_nx;

    logic [N-1:0] a1_s, a2_s, b0_s, b1_s, b2_s;
    logic [N-1:0] f0, f1, f2;
    logic [N-1:0] yk_r;
    logic signed [AW-1:0] acc;

    logic [N-1:0] mul_c, mul_f;
    logic signed [PW-1:0] op_c, op_f, prod;
    logic signed [AW-1:0] prod_ext, uk_acc, shifted;
    logic ovf;
    logic [N-1:0] norm;
    logic accept;

    assign in_ready = (state == IDLE) && !clear;
    assign accept   = in_valid && in_ready;
    assign YK       = yk_r;

    // Operand select for the shared multiplier.
    always_comb begin
        mul_c = '0;
        mul_f = '0;
        unique case (state)
            MAC_A1: begin mul_c = a1_s; mul_f = f1; end
            MAC_A2: begin mul_c = a2_s; mul_f = f2; end
            MAC_B0: begin mul_c = b0_s; mul_f = f0; end
            MAC_B1: begin mul_c = b1_s; mul_f = f1; end
            MAC_B2: begin mul_c = b2_s; mul_f = f2; end
            default: begin mul_c = '0; mul_f = '0; end
        endcase
    end

    assign op_c     = $signed({{N{mul_c[N-1]}}, mul_c});
    assign op_f     = $signed({{N{mul_f[N-1]}}, mul_f});
    assign prod     = op_c * op_f;
    assign prod_ext = $signed({{(AW-PW){prod[PW-1]}}, prod});
    assign uk_acc   = $signed({{(AW-N){UK[N-1]}}, UK}) <<< FRAC;
    assign shifted  = acc >>> FRAC;

    // Out of range when the bits above the N-bit sign are not all equal.
    assign ovf = !((&shifted[AW-1:N-1]) || !(|shifted[AW-1:N-1]));

`ifdef FILTRO_SATURACION_EN
    assign norm = !ovf ? shifted[N-1:0] :
                  shifted[AW-1] ? {1'b1, {(N-1){1'b0}}} :
                                  {1'b0, {(N-1){1'b1}}};
`else
    assign norm = shifted[N-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Fixed eight-step sequence; clear aborts back to IDLE.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (in_valid) state_nx = MAC_A1;
                MAC_A1:  state_nx = MAC_A2;
                MAC_A2:  state_nx = NORM_F;
                NORM_F:  state_nx = MAC_B0;
                MAC_B0:  state_nx = MAC_B1;
                MAC_B1:  state_nx = MAC_B2;
                MAC_B2:  state_nx = NORM_Y;
                NORM_Y:  state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Shadow registers, accumulator, filter history and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1_s      <= '0;
            a2_s      <= '0;
            b0_s      <= '0;
            b1_s      <= '0;
            b2_s      <= '0;
            f0        <= '0;
            f1        <= '0;
            f2        <= '0;
            acc       <= '0;
            yk_r      <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            f0        <= '0;
            f1        <= '0;
            f2        <= '0;
            acc       <= '0;
            yk_r      <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a1_s <= A1;
                        a2_s <= A2;
                        b0_s <= B0;
                        b1_s <= B1;
                        b2_s <= B2;
                        acc  <= uk_acc;
                    end
                end
                MAC_A1, MAC_A2: acc <= acc - prod_ext;
                NORM_F: begin
                    f0  <= norm;
                    acc <= '0;
                    if (ovf) sat_flag <= 1'b1;
                end
                MAC_B0, MAC_B1, MAC_B2: acc <= acc + prod_ext;
                NORM_Y: begin
                    yk_r      <= norm;
                    f2        <= f1;
                    f1        <= f0;
                    out_valid <= 1'b1;
                    if (ovf) sat_flag <= 1'b1;
                end
                default: acc <= acc;
            endcase
        end
    end

endmodule

// File: tb/tb_filtro_iir2_sec.sv
// Scoreboard bench for filtro_iir2_sec (N=16, FRAC=14).
// Expected outputs are hand-computed and queued at acceptance.
module tb_filtro_iir2_sec;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] UK = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A1 = '0, A2 = '0, B0 = '0, B1 = '0, B2 = '0;
    logic [15:0] YK;
    logic        out_valid;
    logic        sat_flag;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [15:0] q_y[$];
    int          q_c[$];

    filtro_iir2_sec #(.N(16), .FRAC(14)) dut (
        .clk(clk), .reset(reset), .clear(clear), .UK(UK),
        .in_valid(in_valid), .in_ready(in_ready),
        .A1(A1), .A2(A2), .B0(B0), .B1(B1), .B2(B2),
        .YK(YK), .out_valid(out_valid), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare every output pulse.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            n_vec++;
            if (q_y.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected: YK=%0d at cycle %0d, none queued",
                         $signed(YK), cyc);
            end else begin
                logic [15:0] ey;
                int ec;
                ey = q_y.pop_front();
                ec = q_c.pop_front();
                if (YK !== ey || cyc != ec) begin
                    n_bad++;
                    $display("FAIL out_yk: got %0d at cycle %0d, want %0d at cycle %0d",
                             $signed(YK), cyc, $signed(ey), ec);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Offer a sample; after acceptance drive garbage with in_valid held
    // for 4 cycles. Returns at the negedge 4 edges after acceptance.
    task automatic send(input int uk, input int a1, input int a2,
                        input int b0, input int b1, input int b2,
                        input bit expect_out, input int exp_y);
        bit got;
        int acc_cyc;
        got = 1'b0;
        acc_cyc = 0;
        @(negedge clk);
        UK = 16'(uk);
        A1 = 16'(a1); A2 = 16'(a2);
        B0 = 16'(b0); B1 = 16'(b1); B2 = 16'(b2);
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                @(negedge clk);
                acc_cyc = cyc;
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got no acceptance want acceptance");
            in_valid = 1'b0;
            return;
        end
        if (expect_out) begin
            q_y.push_back(16'(exp_y));
            q_c.push_back(acc_cyc + 7);
        end
        UK = 16'h7abc;
        A1 = 16'h4321; A2 = 16'h9876;
        B0 = 16'h1111; B1 = 16'h2345; B2 = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            check("busy_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q_y.size() == 0) break;
            @(negedge clk);
        end
        if (q_y.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q_y.size());
            q_y.delete();
            q_c.delete();
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        #1;
        check("clear_in_ready", int'(in_ready), 0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Watch a window in which no output may appear.
    task automatic quiet(input string name);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check({name, "_no_out"}, pulses, 0);
        check({name, "_yk"}, int'($signed(YK)), 0);
        check({name, "_in_ready"}, int'(in_ready), 1);
    endtask

    int wrap_y;

    initial begin
`ifdef FILTRO_SATURACION_EN
        wrap_y = 32767;
`else
        wrap_y = -5536;
`endif
        repeat (3) @(negedge clk);
        check("rst_yk", int'(YK), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sat", int'(sat_flag), 0);
        check("rst_in_ready", int'(in_ready), 1);
        reset = 1'b1;

        // Unity gain, coefficient/UK changes after acceptance ignored.
        send(8192, 0, 0, 16384, 0, 0, 1'b1, 8192);
        drain();
        check("unity_sat", int'(sat_flag), 0);

        // One-pole feedback A1 = -0.5.
        do_clear();
        check("clear_yk", int'(YK), 0);
        send(16384, -8192, 0, 16384, 0, 0, 1'b1, 16384);
        send(0, -8192, 0, 16384, 0, 0, 1'b1, 8192);
        send(0, -8192, 0, 16384, 0, 0, 1'b1, 4096);
        drain();

        // Three-tap FIR, overflow on the third sample.
        do_clear();
        send(30000, 0, 0, 16384, 16384, 16384, 1'b1, 30000);
        send(0, 0, 0, 16384, 16384, 16384, 1'b1, 30000);
        drain();
        check("fir_sat_before", int'(sat_flag), 0);
        send(30000, 0, 0, 16384, 16384, 16384, 1'b1, wrap_y);
        drain();
        check("fir_sat_after", int'(sat_flag), 1);
        do_clear();
        check("clear_sat", int'(sat_flag), 0);

        // Floor truncation of a negative result.
        send(-3, 0, 0, 8192, 0, 0, 1'b1, -2);
        drain();

        // Reset during MAC_B1 discards the sample.
        send(1000, 0, 0, 16384, 0, 0, 1'b1, 1000);
        drain();
        send(1000, 0, 0, 16384, 0, 0, 1'b0, 0);
        reset = 1'b0;
        #1;
        check("rst_async_yk", int'(YK), 0);
        @(negedge clk);
        reset = 1'b1;
        quiet("rst_abort");

        // Clear during MAC_B1 discards the sample.
        send(1000, 0, 0, 16384, 0, 0, 1'b1, 1000);
        drain();
        send(1000, 0, 0, 16384, 0, 0, 1'b0, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        quiet("clr_abort");

        // Clear together with in_valid drops the sample.
        @(negedge clk);
        UK = 16'd500;
        B0 = 16'd16384;
        in_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b0;
        quiet("clr_drop");

        // Block still operational afterwards.
        send(8192, 0, 0, 16384, 0, 0, 1'b1, 8192);
        drain();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/filtro_iir2_sec.md
FILTRO_IIR2_SEC -- requirements
Module: filtro_iir2_sec

Interface
REQ-001 Parameter N, default 16: signed two's-complement width of samples, coefficients and output.
REQ-002 Parameter FRAC, default 14: fractional bits of coefficients; legal range 1 to N-2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous clear of filter history and FSM.
REQ-006 UK  input  N  input sample u(k), signed integer.
REQ-007 in_valid  input  1  UK and coefficients are valid.
REQ-008 in_ready  output  1  block can accept a sample.
REQ-009 A1, A2  input  N each  feedback coefficients, signed QFRAC.
REQ-010 B0, B1, B2  input  N each  feedforward coefficients, signed QFRAC.
REQ-011 YK  output  N  filtered output y(k), signed integer.
REQ-012 out_valid  output  1  one-cycle pulse: YK updated.
REQ-013 sat_flag  output  1  sticky: saturation or wrap occurred since reset/clear.

Function
REQ-014 The block SHALL compute direct-form-II biquad: f(k)=u(k)-A1*f(k-1)-A2*f(k-2); y(k)=B0*f(k)+B1*f(k-1)+B2*f(k-2), using one shared multiplier and one accumulator.
REQ-015 Accumulator SHALL be 2N+2 bits signed; products SHALL be full 2N bits; u(k) SHALL enter the accumulator as UK shifted left by FRAC.
REQ-016 Normalisation SHALL be an arithmetic right shift by FRAC (truncation toward minus infinity), then reduction to N bits per REQ-030.
REQ-017 FSM states: IDLE, MAC_A1, MAC_A2, NORM_F, MAC_B0, MAC_B1, MAC_B2, NORM_Y; one state per cycle, strictly in that order, NORM_Y returning to IDLE.
REQ-018 in_ready SHALL be 1 exactly when state is IDLE and clear is 0.
REQ-019 A sample SHALL be accepted on an edge where in_valid and in_ready are both 1; on that edge UK, A1, A2, B0, B1, B2 SHALL be latched into shadow registers and the accumulator loaded with UK shifted left by FRAC.
REQ-020 Coefficient or UK changes after acceptance SHALL NOT affect the sample in flight.
REQ-021 MAC_A1 and MAC_A2 SHALL subtract A1*f(k-1) and A2*f(k-2); NORM_F SHALL write f(k) and zero the accumulator.
REQ-022 MAC_B0/B1/B2 SHALL add B0*f(k), B1*f(k-1), B2*f(k-2); the B0 term SHALL use the f(k) just written.
REQ-023 On the NORM_Y edge: YK updated, f(k-2)<=f(k-1), f(k-1)<=f(k), out_valid set for one cycle.
REQ-024 Latency: out_valid SHALL be high in the cycle beginning 7 edges after the acceptance edge; throughput one sample per 8 cycles at most.
REQ-025 YK SHALL hold its value between out_valid pulses.
REQ-026 clear SHALL, on its edge, zero f(k-1), f(k-2), accumulator, YK, out_valid and sat_flag and force IDLE, aborting any sample in flight; clear with in_valid on the same edge SHALL drop the sample.
REQ-027 in_valid while not in_ready SHALL be ignored without error.

Reset
REQ-028 reset low SHALL immediately force state IDLE and zero YK, out_valid, sat_flag, f(k-1), f(k-2), accumulator and shadow registers, regardless of clk.
REQ-029 Reset asserted mid-computation SHALL discard the sample; no out_valid SHALL follow release until a new sample is accepted.

Configuration
REQ-030 Macro FILTRO_SATURACION_EN: when defined, normalised values outside N-bit range SHALL clamp to 2^(N-1)-1 or -2^(N-1); when undefined, the low N bits SHALL be kept (wrap-around); sat_flag SHALL be set in either mode whenever the range is exceeded at NORM_F or NORM_Y.

Verification (N=16, FRAC=14)
REQ-031 B0=16384, others 0, UK=8192 -> out_valid 7 edges after acceptance, YK=8192, sat_flag=0.
REQ-032 A1=-8192, B0=16384, others 0, UK=16384,0,0 -> YK=16384, 8192, 4096.
REQ-033 B0=B1=B2=16384, A=0, UK=30000,0 -> YK=30000, then 30000 with history; then UK=30000 again after clear-free run of 30000,30000 -> YK=32767 with macro, -5536 without; sat_flag=1.
REQ-034 B0=8192, others 0, UK=-3 -> YK=-2 (floor truncation).
REQ-035 Accept UK=1000, assert reset low during MAC_B1, release -> no out_valid, YK=0, in_ready=1; same with clear -> identical result.
REQ-036 Change all coefficient inputs to 0 one cycle after acceptance of REQ-031 stimulus -> YK still 8192.
